// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: state encoding and
// default widths.
package seq_det_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_t;

    localparam int unsigned PAT_W_DEF = 4;
    localparam int unsigned LEN_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/seq_det_shift.sv
// Shift register, fill counter and pattern comparator for the serial detector.
// hit is combinational and reflects the post-shift state of the current edge.
module seq_det_shift
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             din,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  sreg;
    logic [PAT_W-1:0]  sreg_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_inc;

    always_comb begin
        sreg_nxt = {sreg[PAT_W-2:0], din};
        fill_inc = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        hit      = shift_en && (sreg_nxt == pattern) && (fill_inc == FILL_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            fill <= '0;
        end else if (clear) begin
            sreg <= '0;
            fill <= '0;
        end else if (shift_en) begin
            sreg <= sreg_nxt;
            // Non-overlapping mode restarts the fill so matched bits are not reused
            fill <= (hit && !overlap) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial pattern detector: latches the configuration,
// sequences IDLE/LOAD/RUN/DONE and keeps the bit and match counters.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             A,
    input  logic             A_valid,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [LEN_W-1:0] bit_cnt;
    logic             shift_en;
    logic             clear;
    logic             hit;
    logic             last_bit;

    assign shift_en = (state == StRun) && A_valid && !abort;
    assign clear    = (state == StLoad) && !abort;
    assign last_bit = ({1'b0, bit_cnt} + (LEN_W + 1)'(1)) == {1'b0, len_q};

    seq_det_shift #(
        .PAT_W (PAT_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .shift_en (shift_en),
        .din      (A),
        .overlap  (ovl_q),
        .pattern  (pat_q),
        .hit      (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            done  <= 1'b0;
            match <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        pat_q <= cfg_pattern;
                        len_q <= cfg_len;
                        ovl_q <= cfg_overlap;
                        busy  <= 1'b1;
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        bit_cnt     <= '0;
                        match_count <= '0;
                        if (len_q == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            state <= StRun;
                        end
                    end
                end
                StRun: begin
                    // Abort wins over a final bit or a match on the same edge
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else if (A_valid) begin
                        bit_cnt <= bit_cnt + LEN_W'(1);
                        match   <= hit;
                        if (hit && (match_count != '1)) begin
                            match_count <= match_count + CNT_W'(1);
                        end
                        if (last_bit) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: a cycle table for the two basic runs plus
// hand-written sequences for gaps, abort, zero length, saturation and reset.
module tb_seq_det_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] cfg_pattern;
    logic [7:0] cfg_len;
    logic       cfg_overlap;
    logic       a;
    logic       a_valid;
    logic       busy, done, match;
    logic [7:0] match_count;
    logic       busy2, done2, match2;
    logic [1:0] match_count2;

    int checks   = 0;
    int failures = 0;

    seq_det_ctrl #(.PAT_W(4), .LEN_W(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .A           (a),
        .A_valid     (a_valid),
        .busy        (busy),
        .done        (done),
        .match       (match),
        .match_count (match_count)
    );

    seq_det_ctrl #(.PAT_W(4), .LEN_W(8), .CNT_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .A           (a),
        .A_valid     (a_valid),
        .busy        (busy2),
        .done        (done2),
        .match       (match2),
        .match_count (match_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit start;
        bit ovl;
        bit a;
        bit av;
        bit busy;
        bit done;
        bit match;
        int cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit s, input bit o, input bit av_a, input bit av,
                                input bit eb, input bit ed, input bit em, input int ec);
        vec_t v;
        v.start = s; v.ovl = o; v.a = av_a; v.av = av;
        v.busy = eb; v.done = ed; v.match = em; v.cnt = ec;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Alternating 1,0,1,0... stream against pattern 1010; config is scrambled after start.
    task automatic do_run(input int len, input bit ovl, input bit gap, input int abort_at,
                          output int done_cyc, output int nmatch, output bit saw_done);
        int k;
        k = 0;
        done_cyc = -1;
        nmatch = 0;
        saw_done = 1'b0;
        cfg_pattern = 4'b1010;
        cfg_len = 8'(len);
        cfg_overlap = ovl;
        abort = 1'b0;
        a_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_pattern = 4'b0000;
        cfg_len = 8'd1;
        cfg_overlap = ~ovl;
        for (int c = 1; c < 60; c++) begin
            a_valid = 1'b0;
            abort = 1'b0;
            if (abort_at > 0 && k == abort_at) begin
                abort = 1'b1;
            end else if (c >= 2 && (!gap || ((c - 2) % 2 == 0)) && k < len) begin
                k++;
                a = k[0];
                a_valid = 1'b1;
            end
            step();
            if (match) nmatch++;
            if (done) begin
                saw_done = 1'b1;
                done_cyc = c;
                break;
            end
            if (abort) break;
        end
        abort = 1'b0;
        a_valid = 1'b0;
    endtask

    int dc, nm;
    bit sd;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; a = 1'b0; a_valid = 1'b0;

        // overlap=1 run of 1010101010, then overlap=0 with the same stream
        add(1,1,0,0, 1,0,0,0); add(0,1,0,0, 1,0,0,0);
        add(0,1,1,1, 1,0,0,0); add(0,1,0,1, 1,0,0,0); add(0,1,1,1, 1,0,0,0);
        add(0,1,0,1, 1,0,1,1); add(0,1,1,1, 1,0,0,1); add(1,1,0,1, 1,0,1,2);
        add(0,1,1,1, 1,0,0,2); add(0,1,0,1, 1,0,1,3); add(0,1,1,1, 1,0,0,3);
        add(0,1,0,1, 0,1,1,4); add(0,1,0,0, 0,0,0,4);
        add(1,0,0,0, 1,0,0,4); add(0,0,0,0, 1,0,0,0);
        add(0,0,1,1, 1,0,0,0); add(0,0,0,1, 1,0,0,0); add(0,0,1,1, 1,0,0,0);
        add(0,0,0,1, 1,0,1,1); add(0,0,1,1, 1,0,0,1); add(0,0,0,1, 1,0,0,1);
        add(0,0,1,1, 1,0,0,1); add(0,0,0,1, 1,0,1,2); add(0,0,1,1, 1,0,0,2);
        add(0,0,0,1, 0,1,0,2); add(0,0,0,0, 0,0,0,2);

        #12;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset match", match, 0);
        chk("reset count", match_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start;
            if (vecs[i].start) begin
                cfg_pattern = 4'b1010; cfg_len = 8'd10; cfg_overlap = vecs[i].ovl;
            end else begin
                cfg_pattern = 4'b0101; cfg_len = 8'd3; cfg_overlap = ~vecs[i].ovl;
            end
            a = vecs[i].a;
            a_valid = vecs[i].av;
            step();
            chk($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d done", i), done, vecs[i].done);
            chk($sformatf("vec%0d match", i), match, vecs[i].match);
            chk($sformatf("vec%0d count", i), match_count, vecs[i].cnt);
        end
        start = 1'b0; a_valid = 1'b0;
        step();

        // Continuous vs. gapped A_valid: same matches, done 9 cycles later
        do_run(10, 1'b1, 1'b0, 0, dc, nm, sd);
        chk("cont done seen", sd, 1);
        chk("cont done cycle", dc, 11);
        chk("cont matches", nm, 4);
        step();
        do_run(10, 1'b1, 1'b1, 0, dc, nm, sd);
        chk("gap done seen", sd, 1);
        chk("gap done cycle", dc, 20);
        chk("gap matches", nm, 4);
        chk("gap count", match_count, 4);
        step();

        // Abort after bit 5
        do_run(10, 1'b1, 1'b0, 5, dc, nm, sd);
        chk("abort no done", sd, 0);
        chk("abort busy", busy, 0);
        chk("abort count", match_count, 1);
        step();
        chk("abort idle done", done, 0);
        chk("abort hold count", match_count, 1);
        start = 1'b1; cfg_len = 8'd10;
        step();
        start = 1'b0;
        chk("restart count before load", match_count, 1);
        step();
        chk("restart count cleared", match_count, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort in run busy", busy, 0);

        // Abort on the same edge as a final matching bit
        cfg_pattern = 4'b1010; cfg_len = 8'd4; cfg_overlap = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            a = (i % 2 == 0); a_valid = 1'b1;
            step();
        end
        a = 1'b0; a_valid = 1'b1; abort = 1'b1;
        step();
        a_valid = 1'b0; abort = 1'b0;
        chk("prio match", match, 0);
        chk("prio done", done, 0);
        chk("prio busy", busy, 0);
        chk("prio count", match_count, 0);
        step();
        chk("prio late done", done, 0);

        // Five overlapping matches: 8-bit counter vs. 2-bit saturating counter
        do_run(12, 1'b1, 1'b0, 0, dc, nm, sd);
        chk("sat done cycle", dc, 13);
        chk("sat matches", nm, 5);
        chk("sat count8", match_count, 5);
        chk("sat count2", match_count2, 3);
        step();

        // Zero length goes LOAD then DONE
        do_run(0, 1'b1, 1'b0, 0, dc, nm, sd);
        chk("len0 done cycle", dc, 1);
        chk("len0 busy", busy, 0);
        chk("len0 count", match_count, 0);
        step();
        chk("len0 done pulse", done, 0);

        // Asynchronous reset mid-run
        cfg_pattern = 4'b1010; cfg_len = 8'd10; cfg_overlap = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 1; i <= 5; i++) begin
            a = i[0]; a_valid = 1'b1;
            step();
        end
        a_valid = 1'b0;
        chk("pre-rst count", match_count, 1);
        chk("pre-rst busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst match", match, 0);
        chk("rst count", match_count, 0);
        #2 rst = 1'b0;
        step();
        step();
        chk("post-rst no done", done, 0);
        do_run(10, 1'b1, 1'b0, 0, dc, nm, sd);
        chk("post-rst done cycle", dc, 11);
        chk("post-rst matches", nm, 4);
        chk("post-rst count", match_count, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter PAT_W, default 4, SHALL set the pattern width in bits.
REQ-002 Parameter LEN_W, default 8, SHALL set the width of the window-length field.
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the match counter.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the reset, asynchronous and active-high.
REQ-006 Port start, input, 1, SHALL request a detection run; it is sampled only in IDLE.
REQ-007 Port abort, input, 1, SHALL terminate a run in progress.
REQ-008 Port cfg_pattern, input, PAT_W, SHALL give the target sequence, MSB first in time.
REQ-009 Port cfg_len, input, LEN_W, SHALL give the number of valid input bits per run.
REQ-010 Port cfg_overlap, input, 1, SHALL select overlapping (1) or non-overlapping (0) detection.
REQ-011 Port A, input, 1, SHALL be the serial data bit.
REQ-012 Port A_valid, input, 1, SHALL qualify A; A is consumed only when A_valid=1.
REQ-013 Port busy, output, 1, SHALL be 1 in LOAD and RUN.
REQ-014 Port done, output, 1, SHALL be a one-cycle completion pulse.
REQ-015 Port match, output, 1, SHALL be a one-cycle pulse per detected pattern.
REQ-016 Port match_count, output, CNT_W, SHALL give the matches counted in the current or last run.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN and DONE.
REQ-018 In IDLE, start=1 SHALL latch cfg_pattern, cfg_len and cfg_overlap, then move to LOAD; config changes after the latch SHALL have no effect on the run.
REQ-019 In LOAD (one cycle), the block SHALL clear the shift register, fill count, bit count and match_count, then move to RUN, or to DONE if the latched length is 0.
REQ-020 In RUN, each A_valid=1 cycle SHALL shift A into the shift-register LSB, increment the bit count, and increment the fill count, saturating at PAT_W.
REQ-021 A match SHALL be the post-shift register equal to the pattern with fill count at PAT_W after the shift; match SHALL assert in the cycle after the sampling edge.
REQ-022 A match SHALL increment match_count, which saturates at 2^CNT_W-1.
REQ-023 With cfg_overlap=0, a match SHALL reset the fill count to 0; with cfg_overlap=1, the fill count SHALL be unaffected.
REQ-024 The edge that samples the cfg_len-th valid bit SHALL move RUN to DONE; if that bit completes a match, match and done SHALL assert together and the match SHALL be counted.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 Cycles in RUN with A_valid=0 SHALL change no state.
REQ-027 abort=1 in LOAD or RUN SHALL return to IDLE on the next edge with no done pulse; match_count SHALL hold its value.
REQ-028 abort takes priority over a simultaneous final bit or match.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 match_count SHALL hold after DONE until the next LOAD.

Reset
REQ-031 rst=1 SHALL force IDLE and set busy=0, done=0, match=0, match_count=0, and clear the shift register and all counters immediately, independent of clk.
REQ-032 Reset asserted mid-run SHALL discard the run without a done pulse.

Structure
REQ-033 Package seq_det_pkg SHALL hold the state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3) and the default PAT_W/LEN_W/CNT_W constants.
REQ-034 Sub-module seq_det_shift SHALL contain the shift register, fill counter and pattern comparator; seq_det_ctrl SHALL hold the FSM and counters.

Verification
REQ-035 pattern=1010, len=10, overlap=1, A=1010101010 continuous -> match after bits 4,6,8,10; match_count=4; done coincident with the 4th match.
REQ-036 Same stimulus with overlap=0 -> matches after bits 4 and 8 only; match_count=2.
REQ-037 The REQ-035 stimulus with A_valid=0 on every other cycle -> the same 4 matches; done arrives 9 cycles later than in REQ-035.
REQ-038 abort after bit 5 of the REQ-035 run -> IDLE; no done; match_count=1; a new start clears it.
REQ-039 len=0 -> LOAD, then DONE; done one cycle later; match_count=0. With CNT_W=2 and 5 matches -> match_count saturates at 3.
REQ-040 rst pulsed mid-RUN between clock edges -> outputs zero immediately; a start 2 cycles later runs normally.
